dm_responder: RTL and testbench

- Data-memory responder: the target side of the pipeline's load/store path.
- Accepts one word read or write request at a time over a valid/ready handshake, holds it for a programmable number of wait states, then returns one response pulse.
- Asserts busy while a transaction is outstanding so the pipeline can freeze its stages.
- Replaces the zero-latency data memory for multi-cycle memory-timing work.

---
 rtl/dm_pkg.sv | 27 ++
 rtl/dm_word_ram.sv | 33 +++
 rtl/dm_responder.sv | 156 +++++++++++++++
 tb/tb_dm_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the data-memory responder.
//   - dm_state_e   : FSM state encoding (IDLE, WAIT, RESP)
//   - DM_WORD_W    : data word width
//   - dm_idx_width : number of word-index bits needed for a given depth
package dm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

    localparam int unsigned DM_WORD_W = 32;

    // Smallest w with 2**w >= depth; depth is a power of two >= 2.
    function automatic int unsigned dm_idx_width(input int unsigned depth);
        int unsigned w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/dm_word_ram.sv
// dm_word_ram: synchronous single-port word array, registered read,
// no reset on contents (maps onto block RAM).
//   clk   : clock
//   we    : write enable, writes wdata to mem[addr] at the edge
//   addr  : word index
//   wdata : write data
//   rdata : mem[addr] as sampled at the previous edge (read-before-write)
module dm_word_ram
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned IDX_W       = dm_idx_width(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IDX_W-1:0]     addr,
    input  logic [DM_WORD_W-1:0] wdata,
    output logic [DM_WORD_W-1:0] rdata
);

    logic [DM_WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [DM_WORD_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
        rdata_q <= mem_q[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dm_responder.sv
// dm_responder: target side of the load/store path. Accepts one word
// request over valid/ready, holds it for WAIT_CYCLES wait states, then
// issues a single-cycle response.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready      : request handshake
//   req_write                : 1 = store, 0 = load
//   req_addr, req_wdata      : byte address, store data
//   resp_valid               : one-cycle response pulse
//   resp_rdata, resp_err     : load data / error flag, valid with resp_valid
//   busy                     : transaction outstanding (pipeline stall)
module dm_responder
    import dm_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    input  logic                 req_write,
    input  logic [31:0]          req_addr,
    input  logic [DM_WORD_W-1:0] req_wdata,
    output logic                 req_ready,
    output logic                 resp_valid,
    output logic [DM_WORD_W-1:0] resp_rdata,
    output logic                 resp_err,
    output logic                 busy
);

    localparam int unsigned IDX_W  = dm_idx_width(DEPTH_WORDS);
    localparam int unsigned HI_LSB = IDX_W + 2;

    dm_state_e            state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 write_q, write_d;
    logic [31:0]          addr_q, addr_d;
    logic [DM_WORD_W-1:0] wdata_q, wdata_d;
    logic                 resp_err_q, resp_err_d;
    logic                 rd_sel_q, rd_sel_d;

    logic                 cur_write;
    logic [31:0]          cur_addr;
    logic [DM_WORD_W-1:0] cur_wdata;
    logic                 cur_err;
    logic                 enter_resp;
    logic                 ram_we;
    logic [DM_WORD_W-1:0] ram_rdata;

    // With zero wait states the RESP entry edge is the accept edge, so the
    // live request must drive the array; otherwise the latched copy does.
    always_comb begin
        if (state_q == ST_IDLE) begin
            cur_write = req_write;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end else begin
            cur_write = write_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    // Misaligned, or any address bit above the index field set.
    assign cur_err = (cur_addr[1:0] != 2'b00) || ((cur_addr >> HI_LSB) != 32'd0);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        write_d    = write_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        resp_err_d = resp_err_q;
        rd_sel_d   = rd_sel_q;
        enter_resp = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                state_d    = ST_IDLE;
                resp_err_d = 1'b0;
                rd_sel_d   = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (enter_resp) begin
            resp_err_d = cur_err;
            rd_sel_d   = !cur_write && !cur_err;
        end
    end

    // Reset on the RESP entry edge must not commit the store.
    assign ram_we = enter_resp && cur_write && !cur_err && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            write_q    <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= '0;
            resp_err_q <= 1'b0;
            rd_sel_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            resp_err_q <= resp_err_d;
            rd_sel_q   <= rd_sel_d;
        end
    end

    dm_word_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (cur_addr[IDX_W+1:2]),
        .wdata(cur_wdata),
        .rdata(ram_rdata)
    );

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = !req_ready;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_err   = resp_err_q;
    // The array read register is not reset, so only pass it through for a
    // good load in RESP.
    assign resp_rdata = rd_sel_q ? ram_rdata : '0;

endmodule

// File: tb/tb_dm_responder.sv
module tb_dm_responder;

    logic clk;
    logic rst;
    // index 0: WAIT_CYCLES=2 instance, index 1: WAIT_CYCLES=0 instance
    logic        req_valid  [2];
    logic        req_write  [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];
    logic        busy       [2];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dm_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .req_ready(req_ready[0]), .resp_valid(resp_valid[0]),
        .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .busy(busy[0])
    );

    dm_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .req_ready(req_ready[1]), .resp_valid(resp_valid[1]),
        .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .busy(busy[1])
    );

    typedef struct {
        int          dut;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NV = 13;
    vec_t tbl [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One complete transaction on instance s: request, accept, scramble the
    // inputs, then check latency, response fields and return to idle.
    task automatic txn(input int idx);
        int s;
        int w;
        int n;
        int lat;
        s = tbl[idx].dut;
        w = (s == 0) ? 2 : 0;
        @(negedge clk);
        req_valid[s] = 1'b1;
        req_write[s] = tbl[idx].wr;
        req_addr[s]  = tbl[idx].addr;
        req_wdata[s] = tbl[idx].wdata;
        n = 0;
        while (!req_ready[s] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", {31'd0, req_ready[s]}, 32'd1);
        @(negedge clk);
        req_valid[s] = 1'b0;
        req_write[s] = ~tbl[idx].wr;
        req_addr[s]  = 32'hFFFF_FFFF;
        req_wdata[s] = 32'h0BAD_0BAD;
        lat = 1;
        while (!resp_valid[s] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, w + 1);
        chk("resp_rdata", resp_rdata[s], tbl[idx].exp_rdata);
        chk("resp_err", {31'd0, resp_err[s]}, {31'd0, tbl[idx].exp_err});
        chk("busy_in_resp", {31'd0, busy[s]}, 32'd1);
        @(negedge clk);
        chk("resp_pulse_end", {31'd0, resp_valid[s]}, 32'd0);
        chk("idle_rdata", resp_rdata[s] | {31'd0, resp_err[s]}, 32'd0);
        chk("idle_busy", {31'd0, busy[s]}, 32'd0);
        $display("txn %0d dut%0d %s addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 idx, s, tbl[idx].wr ? "ST" : "LD", tbl[idx].addr, tbl[idx].wdata,
                 tbl[idx].exp_rdata, tbl[idx].exp_err, lat);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc [4];
        logic [31:0] la [4];
        logic [31:0] le [4];
        int r;
        int n;

        tbl[0]  = '{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        tbl[1]  = '{0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{0, 1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0000_0000, 1'b0};
        tbl[3]  = '{0, 1'b0, 32'h0000_0013, 32'h0,         32'h0000_0000, 1'b1};
        tbl[4]  = '{0, 1'b1, 32'h0000_0100, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
        tbl[5]  = '{0, 1'b1, 32'h8000_0000, 32'h2222_2222, 32'h0000_0000, 1'b1};
        tbl[6]  = '{0, 1'b0, 32'h0000_0000, 32'h0,         32'h1111_1111, 1'b0};
        tbl[7]  = '{0, 1'b1, 32'h0000_00FC, 32'h5A5A_0FF0, 32'h0000_0000, 1'b0};
        tbl[8]  = '{0, 1'b0, 32'h0000_00FC, 32'h0,         32'h5A5A_0FF0, 1'b0};
        tbl[9]  = '{0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h0000_0000, 1'b0};
        tbl[10] = '{0, 1'b0, 32'h0000_0102, 32'h0,         32'h0000_0000, 1'b1};
        tbl[11] = '{1, 1'b1, 32'h0000_003C, 32'hA5A5_A5A5, 32'h0000_0000, 1'b0};
        tbl[12] = '{1, 1'b0, 32'h0000_003C, 32'h0,         32'hA5A5_A5A5, 1'b0};

        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0;
            req_write[s] = 1'b0;
            req_addr[s]  = 32'd0;
            req_wdata[s] = 32'd0;
        end

        // Reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("rst_ready", {31'd0, req_ready[s]}, 32'd1);
            chk("rst_resp_valid", {31'd0, resp_valid[s]}, 32'd0);
            chk("rst_rdata", resp_rdata[s], 32'd0);
            chk("rst_err", {31'd0, resp_err[s]}, 32'd0);
            chk("rst_busy", {31'd0, busy[s]}, 32'd0);
        end
        rst = 1'b0;
        $display("reset checked");

        for (int i = 0; i < NV; i++) begin
            txn(i);
        end

        // Reset in the second WAIT cycle drops a pending store
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 32'h0000_0020;
        req_wdata[0] = 32'h1234_5678;
        n = 0;
        while (!req_ready[0] && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid[0] = 1'b0;
        chk("rstmid_busy_wait1", {31'd0, busy[0]}, 32'd1);
        @(negedge clk);
        chk("rstmid_busy_wait2", {31'd0, busy[0]}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_no_resp", {31'd0, resp_valid[0]}, 32'd0);
        chk("rstmid_busy", {31'd0, busy[0]}, 32'd0);
        chk("rstmid_ready", {31'd0, req_ready[0]}, 32'd1);
        chk("rstmid_rdata", resp_rdata[0], 32'd0);
        chk("rstmid_err", {31'd0, resp_err[0]}, 32'd0);
        r = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid[0]) r++;
        end
        chk("rstmid_quiet", r, 0);
        $display("reset during WAIT: store 12345678 to 00000020 dropped");
        tbl[0] = '{0, 1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 1'b0};
        txn(0);

        // Four loads with req_valid held: acceptances every 4 cycles
        la[0] = 32'h0000_0010; le[0] = 32'hDEAD_BEEF;
        la[1] = 32'h0000_0000; le[1] = 32'h1111_1111;
        la[2] = 32'h0000_00FC; le[2] = 32'h5A5A_0FF0;
        la[3] = 32'h0000_0020; le[3] = 32'hCAFE_F00D;
        r = 0;
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = la[0];
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!req_ready[0] && n < 20) begin
                chk("b2b_busy", {31'd0, busy[0]}, 32'd1);
                if (resp_valid[0]) begin
                    chk("b2b_rdata", resp_rdata[0], (r < 4) ? le[r] : 32'hX);
                    r++;
                end
                @(negedge clk);
                n++;
            end
            acc[k] = cyc;
            @(negedge clk);
            if (k < 3) req_addr[0] = la[k + 1];
            else req_valid[0] = 1'b0;
        end
        repeat (6) begin
            if (resp_valid[0]) begin
                chk("b2b_rdata", resp_rdata[0], (r < 4) ? le[r] : 32'hX);
                r++;
            end
            @(negedge clk);
        end
        chk("b2b_resp_count", r, 4);
        for (int k = 1; k < 4; k++) begin
            chk("b2b_spacing", acc[k] - acc[k - 1], 4);
            $display("b2b acceptance %0d at cycle %0d (gap %0d)", k, acc[k], acc[k] - acc[k - 1]);
        end

        // Zero wait states: store then load held back to back
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        req_addr[1]  = 32'h0000_003C;
        req_wdata[1] = 32'h0F0F_0F0F;
        chk("w0_ready", {31'd0, req_ready[1]}, 32'd1);
        @(negedge clk);
        chk("w0_st_resp", {31'd0, resp_valid[1]}, 32'd1);
        chk("w0_st_rdata", resp_rdata[1], 32'd0);
        chk("w0_st_ready", {31'd0, req_ready[1]}, 32'd0);
        req_write[1] = 1'b0;
        req_wdata[1] = 32'd0;
        @(negedge clk);
        chk("w0_idle_resp", {31'd0, resp_valid[1]}, 32'd0);
        chk("w0_idle_ready", {31'd0, req_ready[1]}, 32'd1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk("w0_ld_resp", {31'd0, resp_valid[1]}, 32'd1);
        chk("w0_ld_rdata", resp_rdata[1], 32'h0F0F_0F0F);
        chk("w0_ld_err", {31'd0, resp_err[1]}, 32'd0);
        @(negedge clk);
        chk("w0_end_resp", {31'd0, resp_valid[1]}, 32'd0);
        $display("w0 back-to-back store/load 0000003C -> 0f0f0f0f");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
